// File: rtl/stream_checker.sv
// stream_checker: compares NCH incoming word streams against expected values
// held in an internal RAM, reporting per-channel completion, a sticky first
// mismatch record and a run timer that freezes on completion or failure.
module stream_checker #(
  parameter int NCH         = 4,
  parameter int DW          = 11,
  parameter int DEPTH       = 39,
  parameter int AW          = 6,
  parameter int TW          = 24,
  parameter int STOP_ON_ERR = 1,
  localparam int CW         = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic              cfg_len_we,
  input  logic [CW-1:0]     cfg_ch,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [DW-1:0]     cfg_data,
  input  logic              start,
  input  logic [NCH-1:0]    rready,
  input  logic [NCH*DW-1:0] in,
  output logic [NCH-1:0]    read,
  output logic [NCH-1:0]    complete,
  output logic              done,
  output logic              err,
  output logic [CW-1:0]     err_ch,
  output logic [AW-1:0]     err_idx,
  output logic [DW-1:0]     err_got,
  output logic [TW-1:0]     timer,
  output logic              running
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE,
    S_FAIL
  } state_t;

  localparam logic [AW-1:0] DEPTH_L = AW'(DEPTH);

  state_t          state_q, state_d;
  logic [DW-1:0]   exp_mem [NCH][DEPTH];
  logic [AW-1:0]   len_q   [NCH];
  logic [AW-1:0]   len_d   [NCH];
  logic [AW-1:0]   count_q [NCH];
  logic [AW-1:0]   count_d [NCH];
  logic [NCH-1:0]  complete_q, complete_d;
  logic [NCH-1:0]  read_q, read_d;
  logic            err_q, err_d;
  logic [CW-1:0]   err_ch_q, err_ch_d;
  logic [AW-1:0]   err_idx_q, err_idx_d;
  logic [DW-1:0]   err_got_q, err_got_d;
  logic [TW-1:0]   timer_q, timer_d;

  logic            cfg_ok;
  logic            ch_ok;
  logic            addr_ok;
  logic [AW-1:0]   len_wdata;
  logic [NCH-1:0]  mism;
  logic            found;
  logic [CW-1:0]   hit_ch;
  logic [AW-1:0]   hit_idx;
  logic [DW-1:0]   hit_got;

  // Config qualification: writes only outside RUN, to existing channels/addresses
  always_comb begin
    cfg_ok    = (state_q != S_RUN);
    ch_ok     = (int'(cfg_ch) < NCH);
    addr_ok   = (cfg_addr < DEPTH_L);
    len_wdata = (cfg_data[AW-1:0] > DEPTH_L) ? DEPTH_L : cfg_data[AW-1:0];
  end

  // Expected-value RAM; deliberately not reset so contents survive rst
  always_ff @(posedge clk) begin
    if (cfg_we && cfg_ok && ch_ok && addr_ok) begin
      exp_mem[cfg_ch][cfg_addr] <= cfg_data;
    end
  end

  // Next-state, handshake, compare, error capture and timer
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    count_d    = count_q;
    complete_d = complete_q;
    read_d     = '0;
    err_d      = err_q;
    err_ch_d   = err_ch_q;
    err_idx_d  = err_idx_q;
    err_got_d  = err_got_q;
    timer_d    = timer_q;
    mism       = '0;
    found      = 1'b0;
    hit_ch     = '0;
    hit_idx    = '0;
    hit_got    = '0;

    if (cfg_len_we && cfg_ok && ch_ok) begin
      len_d[cfg_ch] = len_wdata;
    end

    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) begin
          state_d   = S_RUN;
          timer_d   = '0;
          err_d     = 1'b0;
          err_ch_d  = '0;
          err_idx_d = '0;
          err_got_d = '0;
          for (int unsigned i = 0; i < NCH; i++) begin
            count_d[i]    = '0;
            complete_d[i] = (len_d[i] == '0);
          end
        end
      end
      S_RUN: begin
        if (timer_q != '1) begin
          timer_d = timer_q + 1'b1;
        end
        for (int unsigned i = 0; i < NCH; i++) begin
          if (rready[i] && !read_q[i] && !complete_q[i]) begin
            read_d[i]  = 1'b1;
            count_d[i] = count_q[i] + 1'b1;
            if (count_d[i] == len_q[i]) begin
              complete_d[i] = 1'b1;
            end
            if (in[i*DW +: DW] != exp_mem[i][count_q[i]]) begin
              mism[i] = 1'b1;
            end
          end
        end
        for (int unsigned i = 0; i < NCH; i++) begin
          if (mism[i] && !found) begin
            found   = 1'b1;
            hit_ch  = CW'(i);
            hit_idx = count_q[i];
            hit_got = in[i*DW +: DW];
          end
        end
        if (found && !err_q) begin
          err_d     = 1'b1;
          err_ch_d  = hit_ch;
          err_idx_d = hit_idx;
          err_got_d = hit_got;
        end
        // The read pulse for the failing word lands in the first FAIL cycle,
        // so the mismatched word is still consumed before checking stops.
        if (found && (STOP_ON_ERR != 0)) begin
          state_d = S_FAIL;
        end else if (&complete_q) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, asynchronous active-high reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= '{default: '0};
      count_q    <= '{default: '0};
      complete_q <= '0;
      read_q     <= '0;
      err_q      <= 1'b0;
      err_ch_q   <= '0;
      err_idx_q  <= '0;
      err_got_q  <= '0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      count_q    <= count_d;
      complete_q <= complete_d;
      read_q     <= read_d;
      err_q      <= err_d;
      err_ch_q   <= err_ch_d;
      err_idx_q  <= err_idx_d;
      err_got_q  <= err_got_d;
      timer_q    <= timer_d;
    end
  end

  assign read     = read_q;
  assign complete = complete_q;
  assign done     = (state_q == S_DONE);
  assign err      = err_q;
  assign err_ch   = err_ch_q;
  assign err_idx  = err_idx_q;
  assign err_got  = err_got_q;
  assign timer    = timer_q;
  assign running  = (state_q == S_RUN);

endmodule

// File: tb/tb_stream_checker.sv
// Directed bench for stream_checker: three instances share stimulus (stop on
// error, continue on error, 4-bit timer); the producer follows the selected one.
module tb_stream_checker;

  localparam int DW = 11;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we, cfg_len_we, start;
  logic [1:0]  cfg_ch;
  logic [5:0]  cfg_addr;
  logic [10:0] cfg_data;
  logic [3:0]  rready;
  logic [43:0] in_bus;

  logic [3:0]  read_m, complete_m, read_n, complete_n, read_s, complete_s;
  logic        done_m, err_m, running_m, done_n, err_n, running_n, done_s, err_s, running_s;
  logic [1:0]  err_ch_m, err_ch_n, err_ch_s;
  logic [5:0]  err_idx_m, err_idx_n, err_idx_s;
  logic [10:0] err_got_m, err_got_n, err_got_s;
  logic [23:0] timer_m, timer_n;
  logic [3:0]  timer_s;

  always #5 clk = ~clk;

  stream_checker #(.NCH(4), .DW(11), .DEPTH(39), .AW(6), .TW(24), .STOP_ON_ERR(1)) u_stop (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_len_we(cfg_len_we), .cfg_ch(cfg_ch),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .start(start), .rready(rready), .in(in_bus),
    .read(read_m), .complete(complete_m), .done(done_m), .err(err_m), .err_ch(err_ch_m),
    .err_idx(err_idx_m), .err_got(err_got_m), .timer(timer_m), .running(running_m));

  stream_checker #(.NCH(4), .DW(11), .DEPTH(39), .AW(6), .TW(24), .STOP_ON_ERR(0)) u_cont (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_len_we(cfg_len_we), .cfg_ch(cfg_ch),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .start(start), .rready(rready), .in(in_bus),
    .read(read_n), .complete(complete_n), .done(done_n), .err(err_n), .err_ch(err_ch_n),
    .err_idx(err_idx_n), .err_got(err_got_n), .timer(timer_n), .running(running_n));

  stream_checker #(.NCH(4), .DW(11), .DEPTH(39), .AW(6), .TW(4), .STOP_ON_ERR(1)) u_sat (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_len_we(cfg_len_we), .cfg_ch(cfg_ch),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .start(start), .rready(rready), .in(in_bus),
    .read(read_s), .complete(complete_s), .done(done_s), .err(err_s), .err_ch(err_ch_s),
    .err_idx(err_idx_s), .err_got(err_got_s), .timer(timer_s), .running(running_s));

  int          n_checks = 0;
  int          n_errors = 0;
  int          sel;
  logic [3:0]  rd_sel;
  logic        done_sel;
  logic [10:0] pw [4][48];
  int          pn [4];
  int          pp [4];
  int          rcnt [4];
  logic [3:0]  rd_prev;
  logic [3:0]  hold_off;
  int          wide;

  always_comb begin
    case (sel)
      0:       begin rd_sel = read_m; done_sel = done_m; end
      1:       begin rd_sel = read_n; done_sel = done_n; end
      default: begin rd_sel = read_s; done_sel = done_s; end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] ew(input int k);
    case (k)
      0:       return 11'd5;
      1:       return 11'h7FF;
      2:       return 11'd1023;
      default: return 11'(k * 7);
    endcase
  endfunction

  function automatic int rsum();
    return rcnt[0] + rcnt[1] + rcnt[2] + rcnt[3];
  endfunction

  task automatic drive_prod();
    for (int c = 0; c < 4; c++) begin
      if (!hold_off[c] && pp[c] < pn[c]) begin
        rready[c] = 1'b1;
        in_bus[c*DW +: DW] = pw[c][pp[c]];
      end else begin
        rready[c] = 1'b0;
      end
    end
  endtask

  task automatic setup_prod(input int s);
    sel = s;
    rd_prev = '0;
    hold_off = '0;
    wide = 0;
    for (int c = 0; c < 4; c++) begin
      pn[c] = 3;
      pp[c] = 0;
      rcnt[c] = 0;
      for (int k = 0; k < 48; k++) pw[c][k] = ew(k);
    end
  endtask

  task automatic step();
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      if (rd_sel[c]) begin
        if (rd_prev[c]) wide++;
        rcnt[c]++;
        pp[c]++;
      end
      rd_prev[c] = rd_sel[c];
    end
    drive_prod();
  endtask

  task automatic cfg_exp(input int c, input int a, input logic [10:0] d);
    cfg_we = 1'b1; cfg_ch = 2'(c); cfg_addr = 6'(a); cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic cfg_len(input int c, input int l);
    cfg_len_we = 1'b1; cfg_ch = 2'(c); cfg_data = 11'(l);
    @(negedge clk);
    cfg_len_we = 1'b0;
  endtask

  task automatic restart_all(input int l0, input int l1, input int l2, input int l3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cfg_len(0, l0); cfg_len(1, l1); cfg_len(2, l2); cfg_len(3, l3);
  endtask

  task automatic start_run();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_until_done(input int lim, input string tag);
    int n = 0;
    while (!done_sel && n < lim) begin
      step();
      n++;
    end
    chk(tag, 32'(done_sel), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cfg_we = 0; cfg_len_we = 0; cfg_ch = 0; cfg_addr = 0; cfg_data = 0;
    start = 0; rready = 0; in_bus = '0; sel = 0;
    setup_prod(0);
    repeat (2) @(negedge clk);
    chk("rst_read", 32'(read_m), 0);
    chk("rst_complete", 32'(complete_m), 0);
    chk("rst_done", 32'(done_m), 0);
    chk("rst_err", 32'(err_m), 0);
    chk("rst_timer", 32'(timer_m), 0);
    chk("rst_running", 32'(running_m), 0);
    rst = 1'b0;

    // Load expected words on every channel, plus one out-of-range write
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < 39; k++) cfg_exp(c, k, ew(k));
    cfg_exp(0, 39, 11'h555);

    // Test 1: basic pass; ch1 length written together with an expected word
    cfg_len(0, 3);
    cfg_we = 1'b1; cfg_len_we = 1'b1; cfg_ch = 2'd1; cfg_addr = 6'd38; cfg_data = 11'd3;
    @(negedge clk);
    cfg_we = 1'b0; cfg_len_we = 1'b0;
    cfg_len(2, 3); cfg_len(3, 3);
    setup_prod(0);
    drive_prod();
    start_run();
    chk("t1_running", 32'(running_m), 1);
    chk("t1_timer0", 32'(timer_m), 0);
    chk("t1_complete0", 32'(complete_m), 0);
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_addr = 6'd2; cfg_data = 11'd0;
    step();
    cfg_we = 1'b0;
    run_until_done(40, "t1_done");
    chk("t1_complete", 32'(complete_m), 32'hF);
    chk("t1_err", 32'(err_m), 0);
    chk("t1_timer", 32'(timer_m), 6);
    chk("t1_reads", 32'(rsum()), 12);
    chk("t1_pulse_width", 32'(wide), 0);
    repeat (4) step();
    chk("t1_timer_frozen", 32'(timer_m), 6);

    // Test 2: ch2 index 1 expects -7, producer sends 7
    restart_all(3, 3, 3, 3);
    cfg_exp(2, 1, 11'h7F9);
    setup_prod(0);
    pw[2][1] = 11'h007;
    drive_prod();
    start_run();
    for (int n = 0; n < 20 && !err_m; n++) step();
    chk("t2_err", 32'(err_m), 1);
    chk("t2_err_ch", 32'(err_ch_m), 2);
    chk("t2_err_idx", 32'(err_idx_m), 1);
    chk("t2_err_got", 32'(err_got_m), 32'h007);
    chk("t2_running", 32'(running_m), 0);
    repeat (10) step();
    chk("t2_reads", 32'(rsum()), 8);
    chk("t2_timer", 32'(timer_m), 3);
    chk("t2_done", 32'(done_m), 0);
    cfg_exp(2, 1, ew(1));

    // Test 3: ch1 and ch3 mismatch together, ch0 later; checking continues
    restart_all(3, 3, 3, 3);
    setup_prod(1);
    pw[1][1] = 11'd100;
    pw[3][1] = 11'd200;
    pw[0][2] = 11'd0;
    drive_prod();
    start_run();
    run_until_done(40, "t3_done");
    chk("t3_err", 32'(err_n), 1);
    chk("t3_err_ch", 32'(err_ch_n), 1);
    chk("t3_err_idx", 32'(err_idx_n), 1);
    chk("t3_err_got", 32'(err_got_n), 100);
    chk("t3_timer", 32'(timer_n), 6);
    chk("t3_reads", 32'(rsum()), 12);
    // Restart from DONE clears timer and error record
    setup_prod(1);
    drive_prod();
    start_run();
    chk("t3r_timer0", 32'(timer_n), 0);
    chk("t3r_err0", 32'(err_n), 0);
    chk("t3r_err_got0", 32'(err_got_n), 0);
    chk("t3r_complete0", 32'(complete_n), 0);
    run_until_done(40, "t3r_done");
    chk("t3r_err", 32'(err_n), 0);
    chk("t3r_timer", 32'(timer_n), 6);

    // Test 6: reset mid-run, reload lengths only, rerun from retained RAM
    restart_all(3, 3, 3, 3);
    setup_prod(0);
    drive_prod();
    start_run();
    repeat (3) step();
    chk("t6_pre_timer", 32'(timer_m), 3);
    chk("t6_pre_read", 32'(read_m), 32'hF);
    rst = 1'b1;
    #2;
    chk("t6_read", 32'(read_m), 0);
    chk("t6_running", 32'(running_m), 0);
    chk("t6_timer", 32'(timer_m), 0);
    chk("t6_err_fields", 32'({err_m, err_ch_m, err_idx_m, err_got_m}), 0);
    chk("t6_done_complete", 32'({done_m, complete_m}), 0);
    @(negedge clk);
    rst = 1'b0;
    cfg_len(0, 3); cfg_len(1, 3); cfg_len(2, 3); cfg_len(3, 3);
    setup_prod(0);
    drive_prod();
    start_run();
    run_until_done(40, "t6_done");
    chk("t6_err", 32'(err_m), 0);
    chk("t6_timer_end", 32'(timer_m), 6);
    chk("t6_complete", 32'(complete_m), 32'hF);

    // Test 4: zero length, over-offered stream, saturated length (63 -> 39)
    restart_all(0, 2, 0, 63);
    setup_prod(0);
    pn[0] = 2; pn[1] = 3; pn[2] = 0; pn[3] = 40;
    drive_prod();
    start_run();
    chk("t4_complete0", 32'(complete_m), 32'h5);
    run_until_done(120, "t4_done");
    chk("t4_reads_ch0", 32'(rcnt[0]), 0);
    chk("t4_reads_ch1", 32'(rcnt[1]), 2);
    chk("t4_reads_ch3", 32'(rcnt[3]), 39);
    chk("t4_timer", 32'(timer_m), 78);
    chk("t4_err", 32'(err_m), 0);

    // Test 5: 4-bit timer saturates while ch0 never offers a word
    restart_all(3, 3, 3, 3);
    setup_prod(2);
    hold_off[0] = 1'b1;
    drive_prod();
    start_run();
    repeat (14) step();
    chk("t5_timer14", 32'(timer_s), 14);
    repeat (10) step();
    chk("t5_timer_sat", 32'(timer_s), 15);
    chk("t5_running", 32'(running_s), 1);
    chk("t5_complete", 32'(complete_s), 32'hE);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stream_checker.md
Name: stream_checker

Overview:
- Parametrised successor to the fixed 4-stream output row and free-running completion timer.
- Holds expected values for NCH output streams in internal RAM, loaded through a config port.
- Consumes words from the core complex's downward ports with a registered read handshake and compares each word against the expected value.
- Reports per-channel completion, a sticky mismatch record, and a cycle timer that freezes on completion, on failure or at saturation.

Parameters:
NCH, 4, number of checked streams
DW, 11, data width (signed two's complement)
DEPTH, 39, max expected words per stream
AW, 6, address/length width; DEPTH <= 2**AW - 1
TW, 24, timer width
STOP_ON_ERR, 1, 1 = first mismatch ends the run; 0 = record it and keep checking

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
cfg_we  in  1  write expected word (IDLE/DONE/FAIL only)
cfg_len_we  in  1  write stream length (IDLE/DONE/FAIL only)
cfg_ch  in  $clog2(NCH)  target channel
cfg_addr  in  AW  word index
cfg_data  in  DW  expected word, or length in low AW bits
start  in  1  begin run (pulse)
rready  in  NCH  producer has a valid word on in
in  in  NCH*DW  channel words, ch i at [i*DW +: DW]
read  out  NCH  one-cycle consume pulse per channel
complete  out  NCH  channel received all expected words
done  out  1  all channels complete
err  out  1  sticky mismatch seen
err_ch  out  $clog2(NCH)  channel of first mismatch
err_idx  out  AW  word index of first mismatch
err_got  out  DW  received word at first mismatch
timer  out  TW  run cycle count
running  out  1  state == RUN

Behaviour:
- Reset, asynchronous: state=IDLE, lengths=0, counts=0.
  - Outputs read, complete, done, err, err_ch, err_idx, err_got and timer are all 0.
  - Expected RAM is not cleared.
- States:
  - IDLE -> RUN on start.
  - RUN -> DONE when every channel's complete=1 (sampled registered).
  - RUN -> FAIL on a mismatch when STOP_ON_ERR=1.
  - DONE/FAIL -> RUN on start.
  - start in RUN is ignored.
- Entering RUN: counts, complete, timer, err and the err_* fields all clear.
  - A channel whose length is 0 has complete=1 on the first RUN cycle.
- Config: cfg_we/cfg_len_we are ignored in RUN.
  - A cfg_addr >= DEPTH write is dropped.
  - A length > DEPTH saturates to DEPTH.
  - cfg_we and cfg_len_we in the same cycle: both are applied.
- Handshake for channel i, in RUN:
  - Sampling cycle: rready[i]=1, read[i]=0, complete[i]=0. The checker samples in[i], compares it with exp[i][count[i]], and drives read[i]=1 on the next cycle for exactly one cycle.
  - Count: count[i] increments in that same read cycle. complete[i] sets when count reaches length.
  - Producer contract: it holds in[i] stable until it sees read[i], and must not present the same word again after read.
  - Throughput: max 1 word per 2 cycles per channel. Channels are independent.
- Mismatch:
  - The first mismatch captures err_ch/err_idx/err_got and sets err.
  - On simultaneous mismatches, the lowest channel index wins.
  - The mismatched word is still consumed (read pulses).
  - STOP_ON_ERR=1: enter FAIL; no further read pulses.
  - STOP_ON_ERR=0: continue; later mismatches do not overwrite the err_* fields.
- Completed channel: read stays 0, so extra producer words stall.
- Outside RUN: rready is ignored and read=0.
- timer:
  - Increments each RUN cycle, including the cycle done is detected.
  - Stops at DONE or FAIL.
  - Saturates at all-ones. Saturation does not end the run.
- done = state==DONE. Comparison is full DW-bit equality.
- Reset mid-run returns to IDLE immediately; lengths must be reloaded.

Test Plan:
1. Basic pass: NCH=4, lengths 3,3,3,3. Load values {5,-1,1023} on each channel; start; producers present the matching words, each held until read. Required: 12 read pulses, each one cycle; complete=4'hF; done=1; err=0; timer frozen at the completion cycle count.
2. Mismatch, STOP_ON_ERR=1: ch2 word index 1 expected -7, producer sends 7. Required: err=1, err_ch=2, err_idx=1, err_got=11'h007; state FAIL; no further read; timer frozen.
3. Simultaneous mismatch, STOP_ON_ERR=0: ch1 and ch3 mismatch in the same cycle, then ch0 later. Required: err_ch=1 with its index; later mismatch does not overwrite err_*; run still reaches done=1.
4. Zero and over-length: ch0 len=0; ch1 len=2 while producer offers 3 words. Required: complete[0]=1 on the first RUN cycle; ch1 gets 2 reads then read stays 0 with rready still high.
5. Saturation: TW=4; ch0 producer never asserts rready. Required: timer reaches 15 and holds; state remains RUN.
6. Reset and restart: assert rst mid-run. Required: all outputs 0 and state IDLE. Reload lengths only, then start: expected RAM contents are still used and the run passes. start from DONE reruns and clears timer/err.
